cpu_trace_buffer: RTL



---
 rtl/cpu_trace_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/cpu_trace_buffer.sv
// Retirement trace capture FIFO: records {pc, instr, alu, zero} whenever the
// sampled PC changes, and presents entries show-ahead through valid/ready.
module cpu_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cap_en,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      alu_in,
    input  logic             zero_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_alu,
    output logic             out_zero,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic [15:0]      drop_cnt
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [96:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [15:0]      drop_q, drop_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic             have_last_q, have_last_d;
    logic             cand, push, pop, drop;
    logic [96:0]      head;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign drop_cnt  = drop_q;
    assign out_valid = !empty;

    assign head      = mem_q[rd_ptr_q];
    assign out_pc    = head[96:65];
    assign out_instr = head[64:33];
    assign out_alu   = head[32:1];
    assign out_zero  = head[0];

    // First sample after enable (or reset) is always captured.
    assign cand = cap_en && (!have_last_q || (pc_in != last_pc_q));
    assign pop  = out_valid && out_ready;
    assign push = cand && (!full || pop);
    assign drop = cand && full && !pop;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        drop_d      = drop_q;
        last_pc_d   = last_pc_q;
        have_last_d = 1'b0;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
        if (cap_en) begin
            last_pc_d   = pc_in;
            have_last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            last_pc_q   <= '0;
            have_last_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            last_pc_q   <= last_pc_d;
            have_last_q <= have_last_d;
        end
    end

    // Storage is not reset; a write is suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= {pc_in, instr_in, alu_in, zero_in};
        end
    end

endmodule
